// File: rtl/cpt_prescaler.sv
// Programmable clock-enable prescaler feeding cpt_bin8.
// Emits a one-cycle tick every div+1 active cycles, continuous or one-shot.
module cpt_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activate,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             oneshot,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] div_cur
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_reg;

  // Control FSM with prescale counter; load overrides the state logic
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_reg <= '0;
      tick    <= 1'b0;
    end else if (load) begin
      div_reg <= div_in;
      cnt     <= '0;
      tick    <= 1'b0;
      if (state == HALT)
        state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          tick <= 1'b0;
          if (activate) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (activate) begin
            if (cnt == div_reg) begin
              cnt  <= '0;
              tick <= 1'b1;
              if (oneshot)
                state <= HALT;
            end else begin
              cnt  <= cnt + ONE;
              tick <= 1'b0;
            end
          end else begin
            tick <= 1'b0;
          end
        end
        HALT: begin
          tick <= 1'b0;
          cnt  <= '0;
          if (!activate)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tick  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign div_cur = div_reg;

endmodule
